// File: rtl/nonce_pkg.sv
// Shared nonce-path constants and the serializer state type.
// NONCE_SER_CHECKSUM_EN adds the trailing checksum state.
package nonce_pkg;

  localparam int unsigned NONCE_BYTES = 32;
  localparam int unsigned NONCE_W     = 8 * NONCE_BYTES;
  localparam int unsigned NONCE_CNT_W = $clog2(NONCE_BYTES);

  localparam logic [NONCE_CNT_W-1:0] NONCE_LAST_CNT = NONCE_CNT_W'(NONCE_BYTES - 1);

`ifdef NONCE_SER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StSend, StCsum} ser_state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend} ser_state_e;
`endif

endpackage

// File: rtl/nonce_serializer.sv
// Snapshots the working nonce and streams it LSB-first, one byte per valid/ready beat.
// Define NONCE_SER_CHECKSUM_EN to append an XOR checksum byte after the nonce.
module nonce_serializer
  import nonce_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic               capture_i,
  output logic               busy_o,
  output logic [7:0]         byte_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               done_o
);

  ser_state_e             state_q, state_d;
  logic [NONCE_W-1:0]     snap_q, snap_d;
  logic [NONCE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef NONCE_SER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NONCE_SER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NONCE_SER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef NONCE_SER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (capture_i) begin
          snap_d  = nonce_i;
          cnt_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StSend;
`ifdef NONCE_SER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      StSend: begin
        if (ready_i) begin
          snap_d = snap_q >> 8;
          if (cnt_q == NONCE_LAST_CNT) begin
`ifdef NONCE_SER_CHECKSUM_EN
            // The checksum rides in the bottom byte of the (now empty) shift register.
            snap_d  = {{(NONCE_W - 8){1'b0}}, csum_q ^ snap_q[7:0]};
            csum_d  = csum_q ^ snap_q[7:0];
            state_d = StCsum;
`else
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
`ifdef NONCE_SER_CHECKSUM_EN
            csum_d = csum_q ^ snap_q[7:0];
`endif
          end
        end
      end

`ifdef NONCE_SER_CHECKSUM_EN
      StCsum: begin
        if (ready_i) begin
          snap_d  = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  assign byte_o  = snap_q[7:0];
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
